// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR PRBS generator: control FSM states,
// maximal-length feedback masks (bit i set = state[i] feeds the XOR) and default seed.
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lfsr_state_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;                  // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] TAPS_16 = 16'hD008;               // x^16+x^15+x^13+x^4+1
  localparam logic [23:0] TAPS_24 = 24'hE1_0000;            // x^24+x^23+x^22+x^17+1
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;          // x^32+x^22+x^2+x+1
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000; // x^64+x^63+x^61+x^60+1

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR advance: applies STEP single shifts
// (fb = ^(state & TAPS), next = {state[WIDTH-2:0], fb}) within one cycle.
module lfsr_step #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(32'h8020_0003),
  parameter int unsigned       STEP  = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned k = 0; k < STEP; k++) begin
      s = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    next_o = s;
  end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci LFSR generator with enable, run-time seed load and a
// valid/ready output. Define LFSR_LOCKUP_EN to trap the all-zero state and add the lockup port.
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(TAPS_32),
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(DEFAULT_SEED),
  parameter int unsigned       STEP  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed_in,
  output logic signed [WIDTH-1:0]  random_bits,
  output logic                     out_valid,
`ifdef LFSR_LOCKUP_EN
  output logic                     lockup,
`endif
  input  logic                     out_ready
);

  lfsr_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] adv_state;
  logic             adv_go;
`ifdef LFSR_LOCKUP_EN
  logic             lock_q, lock_d;
`endif

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_step (
    .state_i (state_q),
    .next_o  (adv_state)
  );

  assign out_valid   = (fsm_q == RUN);
  assign random_bits = word_q;
  assign adv_go      = en && (!out_valid || out_ready) && !seed_load;

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: if (adv_go) fsm_d = RUN;
      RUN: begin
        if (seed_load)            fsm_d = IDLE;
        else if (out_ready && !en) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Seed load wins over advance; a pending word is dropped but random_bits keeps its value.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
`ifdef LFSR_LOCKUP_EN
    lock_d  = 1'b0;
`endif
    if (seed_load) begin
      state_d = seed_in;
`ifdef LFSR_LOCKUP_EN
      if (seed_in == '0) begin
        state_d = SEED;
        lock_d  = 1'b1;
      end
`endif
    end else if (adv_go) begin
      state_d = adv_state;
      word_d  = adv_state;
`ifdef LFSR_LOCKUP_EN
      if (adv_state == '0) begin
        state_d = SEED;
        word_d  = SEED;
        lock_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      state_q <= SEED;
      word_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

`ifdef LFSR_LOCKUP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end

  assign lockup = lock_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Self-checking bench for lfsr_prbs_gen: directed test-plan cases, randomized
// control traffic against a behavioural model, and an 8-bit full-period sweep.
module tb_lfsr_prbs_gen;

  localparam logic [31:0] SEED32 = 32'h0000_ACE1;
  localparam logic [63:0] TAPS32 = 64'h8020_0003;
  localparam logic [7:0]  SEED8  = 8'hE1;
  localparam logic [63:0] TAPS8  = 64'hB8;
`ifdef LFSR_LOCKUP_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en, seed_load, out_ready;
  logic [31:0]        seed_in;
  logic signed [31:0] rb;
  logic               ov;
  logic               lk;

  logic               en8, sl8, rdy8;
  logic [7:0]         seed8;
  logic signed [7:0]  rb8;
  logic               ov8;
  logic               lk8;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state for the 32-bit instance
  logic [31:0] m_state, m_word;
  logic        m_valid, m_lock;

  always #5 clk = ~clk;

  lfsr_prbs_gen u_dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .en          (en),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .random_bits (rb),
    .out_valid   (ov),
`ifdef LFSR_LOCKUP_EN
    .lockup      (lk),
`endif
    .out_ready   (out_ready)
  );

  lfsr_prbs_gen #(
    .WIDTH (8),
    .TAPS  (8'hB8),
    .SEED  (8'hE1),
    .STEP  (1)
  ) u_dut8 (
    .clk         (clk),
    .reset_n     (rst_n),
    .en          (en8),
    .seed_load   (sl8),
    .seed_in     (seed8),
    .random_bits (rb8),
    .out_valid   (ov8),
`ifdef LFSR_LOCKUP_EN
    .lockup      (lk8),
`endif
    .out_ready   (rdy8)
  );

`ifndef LFSR_LOCKUP_EN
  assign lk  = 1'b0;
  assign lk8 = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Polynomial recurrence: new low bit is the parity of the tapped bits; word is masked to w bits.
  function automatic logic [63:0] ref_adv(input logic [63:0] s, input int w,
                                          input logic [63:0] taps, input int steps);
    logic [63:0] v;
    int ones;
    v = s;
    for (int k = 0; k < steps; k++) begin
      ones = $countones(v & taps);
      v = (v * 2 + 64'(ones % 2)) % (64'd1 << w);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_state = SEED32;
    m_word  = '0;
    m_valid = 1'b0;
    m_lock  = 1'b0;
  endtask

  task automatic model_clock();
    logic [31:0] n;
    m_lock = 1'b0;
    if (seed_load) begin
      m_valid = 1'b0;
      if (LOCK_EN && seed_in == 32'd0) begin
        m_state = SEED32;
        m_lock  = 1'b1;
      end else begin
        m_state = seed_in;
      end
    end else if (en && (!m_valid || out_ready)) begin
      n = 32'(ref_adv(64'(m_state), 32, TAPS32, 1));
      if (LOCK_EN && n == 32'd0) begin
        n      = SEED32;
        m_lock = 1'b1;
      end
      m_state = n;
      m_word  = n;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    check_eq("model_word",  64'($unsigned(rb)), 64'(m_word));
    check_eq("model_valid", 64'(ov), 64'(m_valid));
    if (LOCK_EN) check_eq("model_lockup", 64'(lk), 64'(m_lock));
  endtask

  initial begin
    logic [255:0] seen;
    logic [63:0]  m8;
    int           distinct;

    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; out_ready = 1'b1; seed_in = '0;
    en8 = 1'b0; sl8 = 1'b0; rdy8 = 1'b1; seed8 = '0;
    model_reset();
    #23;
    check_eq("reset_word",  64'($unsigned(rb)), 64'h0);
    check_eq("reset_valid", 64'(ov), 64'h0);
    check_eq("reset_lockup", 64'(lk), 64'h0);
    @(negedge clk); rst_n = 1'b1;

    tick();
    check_eq("idle_valid", 64'(ov), 64'h0);
    en = 1'b1;
    tick();
    check_eq("first_word",  64'($unsigned(rb)), 64'h0001_59C3);
    check_eq("first_valid", 64'(ov), 64'h1);

    out_ready = 1'b0;
    repeat (3) begin
      tick();
      check_eq("stall_word",  64'($unsigned(rb)), 64'h0001_59C3);
      check_eq("stall_valid", 64'(ov), 64'h1);
    end
    out_ready = 1'b1;
    tick();
    check_eq("second_word", 64'($unsigned(rb)), 64'h0002_B386);
    tick();

    seed_load = 1'b1; seed_in = 32'h0000_0001;
    tick();
    check_eq("seedload_valid", 64'(ov), 64'h0);
    seed_load = 1'b0;
    tick();
    check_eq("seed1_word", 64'($unsigned(rb)), 64'h0000_0003);

    seed_load = 1'b1; seed_in = 32'h0;
    tick();
    check_eq("zero_seed_lockup", 64'(lk), LOCK_EN ? 64'h1 : 64'h0);
    seed_load = 1'b0;
    tick();
    check_eq("zero_seed_lockup_clear", 64'(lk), 64'h0);
    check_eq("zero_seed_word", 64'($unsigned(rb)), LOCK_EN ? 64'h0001_59C3 : 64'h0);
    tick();
    if (!LOCK_EN) check_eq("zero_seed_word2", 64'($unsigned(rb)), 64'h0);

    // Seed load while en=0 still loads; the next advance starts there.
    en = 1'b0; seed_load = 1'b1; seed_in = 32'h0000_0001;
    tick();
    seed_load = 1'b0; en = 1'b1;
    tick();
    check_eq("seed_en0_word", 64'($unsigned(rb)), 64'h0000_0003);

    check_eq("pre_reset_valid", 64'(ov), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset_word",  64'($unsigned(rb)), 64'h0);
    check_eq("midreset_valid", 64'(ov), 64'h0);
    model_reset();
    en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    en = 1'b1;
    tick();
    check_eq("restart_word", 64'($unsigned(rb)), 64'h0001_59C3);

    repeat (600) begin
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      seed_load = ($urandom_range(0, 9) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      tick();
    end
    en = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    tick();

    seen = '0; distinct = 0; m8 = 64'(SEED8);
    en8 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      tick();
      m8 = ref_adv(m8, 8, TAPS8, 1);
      check_eq("w8_word", 64'($unsigned(rb8)), m8);
      if (rb8 == 8'sd0 || seen[8'($unsigned(rb8))]) check_eq("w8_unique", 64'($unsigned(rb8)), 64'hFFFF);
      else begin
        seen[8'($unsigned(rb8))] = 1'b1;
        distinct++;
      end
    end
    check_eq("w8_distinct", 64'(distinct), 64'd255);
    check_eq("w8_period_seed", 64'($unsigned(rb8)), 64'(SEED8));
    check_eq("w8_valid", 64'(ov8), 64'h1);
    en8 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
